// File: rtl/rgb_pwm_ctrl.sv
// PWM front end for the iCE40 hard RGB LED driver: three duty channels, a shared
// period counter, and a command port that loads or fades duties on period boundaries.
`timescale 1ns/1ps

module rgb_pwm_ctrl #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3*PWM_BITS-1:0] cmd_rgb,
    input  logic                  cmd_fade,
    output logic [2:0]            rgb_pwm,
    output logic                  led_en,
    output logic                  period_start,
    output logic                  busy
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FADING  = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [PS_W-1:0]            psc;
    logic [PWM_BITS-1:0]        cnt;
    logic [2:0][PWM_BITS-1:0]   duty, target, stepped, duty_nxt;
    logic                       tick, boundary, accept;
    logic                       ready_nxt, busy_nxt;

    assign tick     = (psc == PS_LAST);
    assign boundary = tick && (cnt == CNT_LAST);
    assign accept   = cmd_valid && cmd_ready;

    // Prescaler and period counter; the wrap tick is the only point duties may change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc <= '0;
            cnt <= '0;
        end else begin
            psc <= tick ? '0 : psc + PS_W'(1);
            if (tick) cnt <= boundary ? '0 : cnt + PWM_BITS'(1);
        end
    end

    // One fade step per channel toward its target, saturating at the target
    always_comb begin
        stepped = duty;
        for (int n = 0; n < 3; n++) begin
            if (duty[n] < target[n])      stepped[n] = duty[n] + PWM_BITS'(1);
            else if (duty[n] > target[n]) stepped[n] = duty[n] - PWM_BITS'(1);
        end
    end

    always_comb begin
        duty_nxt = duty;
        if (boundary) begin
            if (state == PENDING)     duty_nxt = target;
            else if (state == FADING) duty_nxt = stepped;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cmd_fade ? FADING : PENDING;
            PENDING: if (boundary) state_nxt = IDLE;
            FADING:  if (boundary && (stepped == target)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs, computed from the next state so the registered copies line up with it
    always_comb begin
        ready_nxt = 1'b0;
        busy_nxt  = 1'b1;
        if (state_nxt == IDLE) begin
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty         <= '0;
            target       <= '0;
            led_en       <= 1'b0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            period_start <= 1'b0;
            rgb_pwm      <= '0;
        end else begin
            duty         <= duty_nxt;
            if (accept) target <= cmd_rgb;
            if (boundary) led_en <= (duty_nxt != '0);
            cmd_ready    <= ready_nxt;
            busy         <= busy_nxt;
            period_start <= boundary;
            for (int n = 0; n < 3; n++) rgb_pwm[n] <= (cnt < duty[n]);
        end
    end

endmodule
